led_pwm_mmio: RTL

LED_PWM_MMIO -- requirements
Module: led_pwm_mmio

---
 rtl/led_pwm_mmio.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/led_pwm_mmio.sv
// LED PWM controller on a word-addressed memory-mapped bus.
// Register map (offset from BASE_ADDR):
//   0 CTRL   : bit0 EN, bit1 MODE (0 static, 1 PWM)
//   1 PERIOD : PWM period, cnt runs 0..PERIOD
//   2 STATIC : per-channel LED value used in static mode
//   3 WRAPS  : 16-bit wrap counter, any write clears it
//   4+i DUTY : shadow duty for channel i, applied on the next wrap
module led_pwm_mmio #(
    parameter int                   ADDR_SIZE = 10,
    parameter int                   DATA_SIZE = 32,
    parameter int                   NUM_CH    = 8,
    parameter int                   CNT_W     = 8,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR = 10'h3F0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 CLEAR,
    input  logic [ADDR_SIZE-1:0] daddr,
    input  logic [DATA_SIZE-1:0] ddata_w,
    input  logic                 mem_write,
    input  logic                 mem_read,
    output logic [DATA_SIZE-1:0] ddata_r,
    output logic                 hit,
    output logic [NUM_CH-1:0]    LED
);

    localparam logic [ADDR_SIZE-1:0] OFF_CTRL   = ADDR_SIZE'(0);
    localparam logic [ADDR_SIZE-1:0] OFF_PERIOD = ADDR_SIZE'(1);
    localparam logic [ADDR_SIZE-1:0] OFF_STATIC = ADDR_SIZE'(2);
    localparam logic [ADDR_SIZE-1:0] OFF_WRAPS  = ADDR_SIZE'(3);
    localparam logic [ADDR_SIZE-1:0] OFF_DUTY0  = ADDR_SIZE'(4);
    localparam logic [ADDR_SIZE-1:0] REG_COUNT  = ADDR_SIZE'(4 + NUM_CH);

    logic                           en_q, en_d;
    logic                           mode_q, mode_d;
    logic [CNT_W-1:0]               period_q, period_d;
    logic [NUM_CH-1:0]              static_q, static_d;
    logic [15:0]                    wraps_q, wraps_d;
    logic [NUM_CH-1:0][CNT_W-1:0]   shadow_q, shadow_d;
    logic [NUM_CH-1:0][CNT_W-1:0]   active_q, active_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [NUM_CH-1:0]              led_q, led_d;
    logic [DATA_SIZE-1:0]           rdata_q, rdata_d;

    logic [ADDR_SIZE-1:0]           off;
    logic                           wr_en;
    logic                           wr_ctrl, wr_period, wr_static, wr_wraps;
    logic [NUM_CH-1:0]              wr_duty;
    logic                           wrap;
    logic [DATA_SIZE-1:0]           rd_val;
    logic                           unused_wdata;

    // Addresses below BASE_ADDR wrap to large offsets, so one compare covers both ends.
    assign off          = daddr - BASE_ADDR;
    assign hit          = (off < REG_COUNT);
    assign wr_en        = mem_write & hit;
    assign unused_wdata = ^ddata_w;

    assign ddata_r = rdata_q;
    assign LED     = led_q;

    // Write strobe decode per register.
    always_comb begin
        wr_ctrl   = wr_en && (off == OFF_CTRL);
        wr_period = wr_en && (off == OFF_PERIOD);
        wr_static = wr_en && (off == OFF_STATIC);
        wr_wraps  = wr_en && (off == OFF_WRAPS);
        wr_duty   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_duty[i] = wr_en && (off == OFF_DUTY0 + ADDR_SIZE'(i));
        end
    end

    // A period rewrite restarts the count without being counted as a wrap.
    assign wrap = en_q && !wr_period && (cnt_q == period_q);

    // Counter, wrap count and duty double-buffering.
    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        wraps_d  = wraps_q;
        active_d = active_q;
        if (!en_q || wr_period || wrap) begin
            cnt_d = '0;
        end
        if (wr_wraps) begin
            wraps_d = '0;
        end else if (wrap) begin
            wraps_d = wraps_q + 16'd1;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (wrap || !en_q) begin
                active_d[i] = shadow_q[i];
            end
        end
        if (CLEAR) begin
            cnt_d    = '0;
            wraps_d  = '0;
            active_d = '0;
        end
    end

    // Configuration register writes; bits above each field are dropped.
    always_comb begin
        en_d     = en_q;
        mode_d   = mode_q;
        period_d = period_q;
        static_d = static_q;
        shadow_d = shadow_q;
        if (wr_ctrl) begin
            en_d   = ddata_w[0];
            mode_d = ddata_w[1];
        end
        if (wr_period) begin
            period_d = ddata_w[CNT_W-1:0];
        end
        if (wr_static) begin
            static_d = ddata_w[NUM_CH-1:0];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_duty[i]) begin
                shadow_d[i] = ddata_w[CNT_W-1:0];
            end
        end
        if (CLEAR) begin
            en_d     = 1'b0;
            mode_d   = 1'b0;
            period_d = '1;
            static_d = '0;
            shadow_d = '0;
        end
    end

    // LED drive derived from the current count, registered one cycle later.
    always_comb begin
        led_d = '0;
        if (en_q && !mode_q) begin
            led_d = static_q;
        end else if (en_q && mode_q) begin
            for (int i = 0; i < NUM_CH; i++) begin
                led_d[i] = (cnt_q < active_q[i]);
            end
        end
        if (CLEAR) begin
            led_d = '0;
        end
    end

    // Read mux over pre-write register values.
    always_comb begin
        rd_val = '0;
        case (off)
            OFF_CTRL:   rd_val[1:0]        = {mode_q, en_q};
            OFF_PERIOD: rd_val[CNT_W-1:0]  = period_q;
            OFF_STATIC: rd_val[NUM_CH-1:0] = static_q;
            OFF_WRAPS:  rd_val[15:0]       = wraps_q;
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (off == OFF_DUTY0 + ADDR_SIZE'(i)) begin
                        rd_val[CNT_W-1:0] = shadow_q[i];
                    end
                end
            end
        endcase
    end

    // Read data register: misses return zero, idle cycles hold.
    always_comb begin
        rdata_d = rdata_q;
        if (mem_read) begin
            rdata_d = hit ? rd_val : '0;
        end
        if (CLEAR) begin
            rdata_d = '0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            en_q     <= 1'b0;
            mode_q   <= 1'b0;
            period_q <= '1;
            static_q <= '0;
            wraps_q  <= '0;
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            led_q    <= '0;
            rdata_q  <= '0;
        end else begin
            en_q     <= en_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            static_q <= static_d;
            wraps_q  <= wraps_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            led_q    <= led_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule
